// File: rtl/grant_decoder.sv
// ---------------------------------------------------------------------------
// grant_decoder
//
// Turns an encoded requester index back into a one-hot grant. An accepted
// index is held as a grant for HOLD cycles, then released through a single
// dead (GAP) cycle before the next index can be taken. An abort ends a grant
// early. Completed grants are counted, and an accepted index that names no
// requester raises a sticky error flag.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   enc          encoded index of the winning requester (W bits)
//   valid        enc is meaningful this cycle
//   ready        block can accept an index (IDLE and not in reset)
//   abort        end the current grant early (only looked at in GRANT)
//   grant        registered one-hot grant (N bits)
//   grant_valid  high exactly when grant is nonzero
//   done         pulse in the last cycle of a full-length grant
//   err          sticky out-of-range flag, cleared only by rst
//   grant_cnt    count of completed (non-aborted) grants, wraps at 256
// ---------------------------------------------------------------------------
module grant_decoder #(
    parameter int N    = 8,
    parameter int W    = $clog2(N),
    parameter int HOLD = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] enc,
    input  logic         valid,
    output logic         ready,
    input  logic         abort,
    output logic [N-1:0] grant,
    output logic         grant_valid,
    output logic         done,
    output logic         err,
    output logic [7:0]   grant_cnt
);

    // Hold counter only needs to reach HOLD-1; keep at least one bit.
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    enc_q, enc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            gv_q, gv_d;
    logic            err_q, err_d;
    logic [7:0]      gcnt_q, gcnt_d;

    logic            accept;
    logic            in_range;
    logic            last_cycle;

    // ready depends only on state and rst, never on valid.
    assign ready  = (state_q == ST_IDLE) & ~rst;
    assign accept = valid & ready;

    // One extra bit so that N itself is representable (e.g. N=256, W=8).
    assign in_range = ({1'b0, enc} < (W+1)'(N));

    assign last_cycle = (state_q == ST_GRANT) && (cnt_q == '0);

    // Abort in the last grant cycle cancels the completion, so the pulse is
    // masked by the live abort input.
    assign done = last_cycle & ~abort;

    always_comb begin
        state_d = state_q;
        enc_d   = enc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        gcnt_d  = gcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_range) begin
                        state_d = ST_GRANT;
                        enc_d   = enc;
                        cnt_d   = CW'(HOLD - 1);
                    end else begin
                        // Nothing to grant: stay IDLE, remember the fault.
                        err_d = 1'b1;
                    end
                end
            end
            ST_GRANT: begin
                if (abort) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    gcnt_d  = gcnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grant is decoded from the next state so the output itself is a flop.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign grant_d[gi] = (state_d == ST_GRANT) && (enc_d == W'(gi));
        end
    endgenerate

    assign gv_d = (state_d == ST_GRANT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            enc_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            gv_q    <= 1'b0;
            err_q   <= 1'b0;
            gcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            enc_q   <= enc_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            gv_q    <= gv_d;
            err_q   <= err_d;
            gcnt_q  <= gcnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = gv_q;
    assign err         = err_q;
    assign grant_cnt   = gcnt_q;

endmodule

// File: tb/tb_grant_decoder.sv
// ---------------------------------------------------------------------------
// tb_grant_decoder
//
// Drives two decoders (N=8 and N=6, both HOLD=4, both with a 3-bit index)
// from the same stimulus. A timeline model tracks, per instance, which
// absolute cycles carry a grant, when the block becomes ready again, the
// completed-grant count and the error flag. Every cycle all outputs of both
// instances are compared against it.
// ---------------------------------------------------------------------------
module tb_grant_decoder;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] enc = 3'd0;

    logic       ready8, gv8, done8, err8;
    logic [7:0] grant8, cnt8;
    logic       ready6, gv6, done6, err6;
    logic [5:0] grant6;
    logic [7:0] cnt6;

    always #5 clk = ~clk;

    grant_decoder #(.N(8), .HOLD(HOLD)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .enc         (enc),
        .valid       (valid),
        .ready       (ready8),
        .abort       (abort),
        .grant       (grant8),
        .grant_valid (gv8),
        .done        (done8),
        .err         (err8),
        .grant_cnt   (cnt8)
    );

    grant_decoder #(.N(6), .HOLD(HOLD)) u_dut6 (
        .clk         (clk),
        .rst         (rst),
        .enc         (enc),
        .valid       (valid),
        .ready       (ready6),
        .abort       (abort),
        .grant       (grant6),
        .grant_valid (gv6),
        .done        (done6),
        .err         (err6),
        .grant_cnt   (cnt6)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Model state, index 0 = N8 instance, index 1 = N6 instance.
    int cyc = 0;
    int nreq[2];
    int g_begin[2];    // first cycle of current/last grant
    int g_end[2];      // first cycle no longer granted
    int g_last[2];     // cycle in which a full-length grant would complete
    int idle_from[2];  // first cycle ready may be high
    int owner[2];
    int cnt_m[2];
    bit err_m[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit m_in_grant(int i);
        return (cyc >= g_begin[i]) && (cyc < g_end[i]);
    endfunction

    function automatic bit m_ready(int i);
        return (rst == 1'b0) && (cyc >= idle_from[i]);
    endfunction

    task automatic check_all();
        logic [31:0] o_rdy, o_g, o_gv, o_dn, o_err, o_cnt;
        logic [31:0] e_g;
        bit ing;
        string nm;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                nm = "n8";
                o_rdy = {31'd0, ready8}; o_g = {24'd0, grant8}; o_gv = {31'd0, gv8};
                o_dn = {31'd0, done8};   o_err = {31'd0, err8}; o_cnt = {24'd0, cnt8};
            end else begin
                nm = "n6";
                o_rdy = {31'd0, ready6}; o_g = {26'd0, grant6}; o_gv = {31'd0, gv6};
                o_dn = {31'd0, done6};   o_err = {31'd0, err6}; o_cnt = {24'd0, cnt6};
            end
            ing = m_in_grant(i);
            e_g = ing ? (32'd1 << owner[i]) : 32'd0;
            chk({nm, ".ready"},       o_rdy, {31'd0, m_ready(i)});
            chk({nm, ".grant"},       o_g,   e_g);
            chk({nm, ".grant_valid"}, o_gv,  {31'd0, ing});
            chk({nm, ".done"},        o_dn,  {31'd0, ing && (cyc == g_last[i]) && !abort});
            chk({nm, ".err"},         o_err, {31'd0, err_m[i]});
            chk({nm, ".grant_cnt"},   o_cnt, cnt_m[i]);
        end
    endtask

    // One clock cycle: drive inputs, check outputs, then advance the model.
    task automatic step(input logic r, input logic v, input logic [2:0] e, input logic a);
        bit ing[2];
        bit rdy[2];
        int n;
        @(negedge clk);
        rst = r; valid = v; enc = e; abort = a;
        #1;
        if (cyc >= 1) check_all();
        for (int i = 0; i < 2; i++) begin
            ing[i] = m_in_grant(i);
            rdy[i] = m_ready(i);
        end
        @(posedge clk);
        n = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                g_begin[i] = 0; g_end[i] = 0; g_last[i] = -1;
                idle_from[i] = n; cnt_m[i] = 0; err_m[i] = 1'b0;
            end else if (rdy[i] && v) begin
                if (int'(e) < nreq[i]) begin
                    g_begin[i]   = n;
                    g_end[i]     = n + HOLD;
                    g_last[i]    = n + HOLD - 1;
                    idle_from[i] = n + HOLD + 1;
                    owner[i]     = int'(e);
                    $display("accept n%0d enc=%0d at cycle %0d", nreq[i], e, cyc);
                end else begin
                    err_m[i] = 1'b1;
                    $display("reject n%0d enc=%0d out of range at cycle %0d", nreq[i], e, cyc);
                end
            end else if (ing[i]) begin
                if (a) begin
                    g_end[i]     = n;
                    idle_from[i] = n + 1;
                end else if (cyc == g_last[i]) begin
                    cnt_m[i] = (cnt_m[i] + 1) % 256;
                end
            end
        end
        cyc = n;
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) step(1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        nreq[0] = 8; nreq[1] = 6;
        for (int i = 0; i < 2; i++) begin
            g_begin[i] = 0; g_end[i] = 0; g_last[i] = -1; idle_from[i] = 0;
            owner[i] = 0; cnt_m[i] = 0; err_m[i] = 1'b0;
        end

        // Reset, then a single grant of index 5.
        step(1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b0, 1'b1, 3'd5, 1'b0);
        idle(7);

        // Back-to-back with valid held: index 0, then 7.
        step(1'b0, 1'b1, 3'd0, 1'b0);
        for (int j = 0; j < 12; j++) step(1'b0, 1'b1, 3'd7, 1'b0);
        idle(3);

        // Abort in the second grant cycle.
        step(1'b0, 1'b1, 3'd3, 1'b0);
        step(1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 1'b1);
        idle(3);

        // Abort in the last grant cycle.
        step(1'b0, 1'b1, 3'd3, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 3'd0, 1'b1);
        idle(3);

        // Out-of-range for the N=6 instance, then a normal index.
        step(1'b0, 1'b1, 3'd6, 1'b0);
        step(1'b0, 1'b1, 3'd2, 1'b0);
        idle(8);

        // Reset in the second grant cycle.
        step(1'b0, 1'b1, 3'd1, 1'b0);
        step(1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 3'd0, 1'b0);
        idle(3);

        // Randomized traffic.
        for (int j = 0; j < 400; j++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0);
        end

        // Count wrap: 256+ full grants with valid held.
        step(1'b1, 1'b0, 3'd0, 1'b0);
        for (int j = 0; j < 257 * (HOLD + 2) + 2; j++)
            step(1'b0, 1'b1, 3'($urandom_range(0, 5)), 1'b0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
